// File: rtl/beep_bank.sv
// beep_bank: polyphonic square-wave voices with attack/sustain/release envelopes.
// Optional DC blocker on the mixed output when BEEP_BANK_HPF_EN is defined.
module beep_bank #(
    parameter int CLOCK_RATE    = 1000000,
    parameter int SAMPLE_RATE   = 48000,
    parameter int CHANNELS      = 4,
    parameter int PHASE_W       = 24,
    parameter int AMP           = 6826,
    parameter int ATTACK_SHIFT  = 6,
    parameter int RELEASE_SHIFT = 8,
    parameter int HPF_SHIFT     = 6
) (
    input  logic                          clk,
    input  logic                          I_RSTn,
    input  logic                          audio_clk_en,
    input  logic [CHANNELS-1:0]           beep_en,
    input  logic [CHANNELS*PHASE_W-1:0]   freq,
    output logic [CHANNELS-1:0]           busy,
    output logic signed [15:0]            out
);

    localparam int MIX_W = 16 + $clog2(CHANNELS);
    localparam logic [14:0] ENV_MAX = 15'h7fff;
    localparam logic signed [32:0] AMP_S = 33'(AMP);
    localparam logic signed [MIX_W-1:0] SAT_HI = MIX_W'(32767);
    localparam logic signed [MIX_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ATTACK,
        S_SUSTAIN,
        S_RELEASE
    } vstate_t;

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("beep_bank: CHANNELS must be 1..16");
    end
    if (SAMPLE_RATE <= 0 || CLOCK_RATE < SAMPLE_RATE ||
        HPF_SHIFT < 1 || HPF_SHIFT > 15) begin : g_bad_rate
        $error("beep_bank: bad rate or HPF_SHIFT");
    end

    logic signed [15:0] samp [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_voice
        vstate_t             state_q, state_d;
        logic [14:0]         env_q, env_d;
        logic [PHASE_W-1:0]  phase_q, phase_d, step;
        logic [15:0]         atk_sum;
        logic [14:0]         rel_step;
        logic signed [32:0]  sq, env_s, prod;

        assign step     = freq[i*PHASE_W +: PHASE_W];
        assign atk_sum  = {1'b0, env_q}
                        + 16'((ENV_MAX - env_q) >> ATTACK_SHIFT)
                        + 16'd1;
        assign rel_step = (env_q >> RELEASE_SHIFT) + 15'd1;

        // Square level scaled by the envelope; idle voices are silent.
        assign sq      = phase_q[PHASE_W-1] ? AMP_S : -AMP_S;
        assign env_s   = 33'(env_q);
        assign prod    = sq * env_s;
        assign samp[i] = (state_q == S_IDLE) ? 16'sd0 : 16'(prod >>> 15);
        assign busy[i] = (state_q != S_IDLE);

        // Envelope FSM and phase accumulator next-state logic.
        always_comb begin
            state_d = state_q;
            env_d   = env_q;
            phase_d = phase_q;
            unique case (state_q)
                S_IDLE: begin
                    if (beep_en[i]) begin
                        state_d = S_ATTACK;
                        env_d   = '0;
                        phase_d = '0;
                    end
                end
                S_ATTACK: begin
                    phase_d = phase_q + step;
                    if (!beep_en[i]) begin
                        state_d = S_RELEASE;
                    end else if (atk_sum >= {1'b0, ENV_MAX}) begin
                        env_d   = ENV_MAX;
                        state_d = S_SUSTAIN;
                    end else begin
                        env_d = atk_sum[14:0];
                    end
                end
                S_SUSTAIN: begin
                    phase_d = phase_q + step;
                    env_d   = ENV_MAX;
                    if (!beep_en[i]) state_d = S_RELEASE;
                end
                S_RELEASE: begin
                    phase_d = phase_q + step;
                    if (beep_en[i]) begin
                        state_d = S_ATTACK;
                    end else if (env_q <= rel_step) begin
                        env_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        env_d = env_q - rel_step;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Voice state advances only on sample ticks.
        always_ff @(posedge clk) begin
            if (!I_RSTn) begin
                state_q <= S_IDLE;
                env_q   <= '0;
                phase_q <= '0;
            end else if (audio_clk_en) begin
                state_q <= state_d;
                env_q   <= env_d;
                phase_q <= phase_d;
            end
        end
    end

    logic signed [MIX_W-1:0] mix_sum;
    logic signed [15:0]      mix_sat;

    // Wide sum of all voices, then clamp to the 16-bit sample range.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_sum = mix_sum + MIX_W'(samp[i]);
        end
        if (mix_sum > SAT_HI) begin
            mix_sat = 16'sh7fff;
        end else if (mix_sum < SAT_LO) begin
            mix_sat = 16'sh8000;
        end else begin
            mix_sat = 16'(mix_sum);
        end
    end

`ifdef BEEP_BANK_HPF_EN
    logic signed [15:0] m_prev, y_prev, y_sat;
    logic signed [17:0] y_raw;

    // First-order DC blocker on the saturated mix.
    always_comb begin
        y_raw = 18'(mix_sat) - 18'(m_prev) + 18'(y_prev)
              - 18'(y_prev >>> HPF_SHIFT);
        if (y_raw > 18'sd32767) begin
            y_sat = 16'sh7fff;
        end else if (y_raw < -18'sd32768) begin
            y_sat = 16'sh8000;
        end else begin
            y_sat = 16'(y_raw);
        end
    end

    // Filter history and output sample register.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            m_prev <= '0;
            y_prev <= '0;
            out    <= '0;
        end else if (audio_clk_en) begin
            m_prev <= mix_sat;
            y_prev <= y_sat;
            out    <= y_sat;
        end
    end
`else
    // Output sample register, one tick behind voice state.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            out <= '0;
        end else if (audio_clk_en) begin
            out <= mix_sat;
        end
    end
`endif

endmodule
